// File: rtl/text_lcd_engine_pkg.sv
// Shared definitions for the text LCD engine: controller opcodes, FSM encoding
// and the DDRAM start address of each display line.
package text_lcd_engine_pkg;

  localparam logic [7:0] CMD_FUNC_2LINE = 8'h38;
  localparam logic [7:0] CMD_FUNC_1LINE = 8'h30;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

  typedef enum logic [3:0] {
    PWR_WAIT,
    FUNC_SET,
    DISP_CTL,
    ENTRY,
    CLEAR,
    CLR_WAIT,
    IDLE,
    LINE_ADDR,
    LINE_DATA,
    CURSOR
  } state_t;

  // Lines 2 and 3 of a 4-line panel continue lines 0 and 1 in DDRAM.
  function automatic logic [6:0] line_base(input logic [1:0] line, input int cols);
    case (line)
      2'd0:    line_base = 7'h00;
      2'd1:    line_base = 7'h40;
      2'd2:    line_base = 7'(cols);
      default: line_base = 7'(8'h40 + cols);
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Two-cycle LCD bus write: strobe high with rs/data, then strobe low holding them.
// A request is accepted (ack) only while the strobe is low, so writes can run back to back.
module lcd_bus_writer (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  assign ack = req & ~lcd_e;

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (lcd_e) begin
      lcd_e <= 1'b0;
    end else if (req) begin
      lcd_e    <= 1'b1;
      lcd_rs   <= rs;
      lcd_data <= data;
    end
  end

endmodule

// File: rtl/text_lcd_engine.sv
// Character LCD engine: power-on init, full-text refreshes from a snapshot buffer,
// and incremental display-mode / cursor rewrites driven by dirty flags.
module text_lcd_engine
  import text_lcd_engine_pkg::*;
#(
  parameter int LINES      = 2,
  parameter int COLS       = 16,
  parameter int PWR_CYCLES = 70,
  parameter int CLR_CYCLES = 2
) (
  input  logic                    clk_100hz,
  input  logic                    rst,
  input  logic [LINES*COLS*8-1:0] text,
  input  logic                    update_req,
  input  logic                    cursor_en,
  input  logic                    blink_en,
  input  logic [6:0]              cursor_addr,
  output logic                    lcd_e,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic [7:0]              lcd_data,
  output logic                    busy,
  output logic                    done
);

  localparam int TEXT_W = LINES * COLS * 8;

  state_t            state;
  logic [15:0]       cnt;
  logic [1:0]        line;
  logic [4:0]        col;
  logic [TEXT_W-1:0] snap;
  logic              sent;
  logic              refreshing;
  logic              initialized;
  logic              refresh_pending;
  logic              mode_dirty;
  logic              cursor_dirty;
  logic              update_prev;
  logic [1:0]        mode_prev;
  logic [6:0]        addr_prev;

  logic       upd_rise, mode_chg, addr_chg;
  logic       wr_req, wr_rs, wr_ack;
  logic [7:0] wr_data;

  assign upd_rise = update_req & ~update_prev;
  assign mode_chg = ({cursor_en, blink_en} != mode_prev);
  assign addr_chg = (cursor_addr != addr_prev);
  assign busy     = (state != IDLE);
  assign lcd_rw   = 1'b0;

  // DISP_CTL and CURSOR drop req once accepted ('sent') and wait out the hold cycle.
  always_comb begin
    wr_req  = 1'b0;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state)
      FUNC_SET: begin
        wr_req  = 1'b1;
        wr_data = (LINES > 1) ? CMD_FUNC_2LINE : CMD_FUNC_1LINE;
      end
      DISP_CTL: begin
        wr_req  = ~sent;
        wr_data = CMD_DISP_ON | {6'b0, cursor_en, blink_en};
      end
      ENTRY: begin
        wr_req  = 1'b1;
        wr_data = CMD_ENTRY_INC;
      end
      CLEAR: begin
        wr_req  = 1'b1;
        wr_data = CMD_CLEAR;
      end
      LINE_ADDR: begin
        wr_req  = 1'b1;
        wr_data = CMD_SET_DDRAM | {1'b0, line_base(line, COLS)};
      end
      LINE_DATA: begin
        wr_req  = 1'b1;
        wr_rs   = 1'b1;
        wr_data = snap[TEXT_W-1 -: 8];
      end
      CURSOR: begin
        wr_req  = ~sent;
        wr_data = CMD_SET_DDRAM | {1'b0, cursor_addr};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      state           <= PWR_WAIT;
      cnt             <= '0;
      line            <= '0;
      col             <= '0;
      snap            <= '0;
      sent            <= 1'b0;
      refreshing      <= 1'b0;
      initialized     <= 1'b0;
      refresh_pending <= 1'b0;
      mode_dirty      <= 1'b0;
      cursor_dirty    <= 1'b0;
      update_prev     <= 1'b0;
      mode_prev       <= '0;
      addr_prev       <= '0;
      done            <= 1'b0;
    end else begin
      update_prev     <= update_req;
      mode_prev       <= {cursor_en, blink_en};
      addr_prev       <= cursor_addr;
      refresh_pending <= refresh_pending | upd_rise;
      mode_dirty      <= mode_dirty | mode_chg;
      cursor_dirty    <= cursor_dirty | addr_chg;
      done            <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (cnt == 16'(PWR_CYCLES - 1)) begin
            cnt   <= '0;
            state <= FUNC_SET;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FUNC_SET: if (wr_ack) state <= DISP_CTL;
        DISP_CTL: begin
          if (wr_ack) begin
            if (initialized) sent <= 1'b1;
            else state <= ENTRY;
          end else if (sent && !lcd_e) begin
            sent  <= 1'b0;
            state <= IDLE;
          end
        end
        ENTRY: if (wr_ack) state <= CLEAR;
        CLEAR: begin
          if (wr_ack) begin
            cnt   <= '0;
            state <= CLR_WAIT;
          end
        end
        // Two cycles cover the clear write itself, the rest is the extra settle time.
        CLR_WAIT: begin
          if (cnt == 16'(CLR_CYCLES + 1)) begin
            cnt             <= '0;
            initialized     <= 1'b1;
            refresh_pending <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        IDLE: begin
          if (refresh_pending) begin
            refresh_pending <= upd_rise;
            snap            <= text;
            line            <= '0;
            refreshing      <= 1'b1;
            state           <= LINE_ADDR;
          end else if (mode_dirty) begin
            mode_dirty <= mode_chg;
            state      <= DISP_CTL;
          end else if (cursor_dirty) begin
            cursor_dirty <= addr_chg;
            state        <= CURSOR;
          end
        end
        LINE_ADDR: begin
          if (wr_ack) begin
            col   <= '0;
            state <= LINE_DATA;
          end
        end
        LINE_DATA: begin
          if (wr_ack) begin
            snap <= snap << 8;
            if (col == 5'(COLS - 1)) begin
              if (line == 2'(LINES - 1)) begin
                state <= CURSOR;
              end else begin
                line  <= line + 2'd1;
                state <= LINE_ADDR;
              end
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        CURSOR: begin
          if (wr_ack) begin
            sent <= 1'b1;
          end else if (sent && !lcd_e) begin
            sent       <= 1'b0;
            done       <= refreshing;
            refreshing <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_bus_writer u_writer (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .req       (wr_req),
    .rs        (wr_rs),
    .data      (wr_data),
    .ack       (wr_ack),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data)
  );

endmodule

// File: tb/tb_text_lcd_engine.sv
// Scoreboard bench: a 2x16 and a 4x20 engine; every expected bus write is queued
// when stimulus is driven and compared as the write strobe appears.
module tb_text_lcd_engine;

  localparam int A_LINES = 2;
  localparam int A_COLS  = 16;
  localparam int B_LINES = 4;
  localparam int B_COLS  = 20;
  localparam int PWR     = 70;
  localparam int A_LAT   = 2 * (A_LINES * (A_COLS + 1) + 1);
  localparam int B_LAT   = 2 * (B_LINES * (B_COLS + 1) + 1);

  typedef struct packed {
    logic       start;
    logic       rs;
    logic [7:0] data;
  } wr_t;

  logic clk_100hz = 1'b0;
  always #5 clk_100hz = ~clk_100hz;

  logic                       rst_a, rst_b;
  logic [A_LINES*A_COLS*8-1:0] a_text;
  logic [B_LINES*B_COLS*8-1:0] b_text;
  logic       a_upd, a_cen, a_ben, b_upd;
  logic [6:0] a_caddr;
  logic       a_e, a_rs, a_rw, a_busy, a_done;
  logic       b_e, b_rs, b_rw, b_busy, b_done;
  logic [7:0] a_data, b_data;

  wr_t qa[$];
  wr_t qb[$];
  int  checks = 0;
  int  failures = 0;
  int  cycle = 0;
  int  start_cyc[2];
  int  dones[2];
  int  nwr[2];
  int  first_write_a = -1;

  text_lcd_engine #(.LINES(A_LINES), .COLS(A_COLS), .PWR_CYCLES(PWR), .CLR_CYCLES(2)) dut_a (
    .clk_100hz(clk_100hz), .rst(rst_a), .text(a_text), .update_req(a_upd),
    .cursor_en(a_cen), .blink_en(a_ben), .cursor_addr(a_caddr),
    .lcd_e(a_e), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_data(a_data), .busy(a_busy), .done(a_done)
  );

  text_lcd_engine #(.LINES(B_LINES), .COLS(B_COLS), .PWR_CYCLES(PWR), .CLR_CYCLES(2)) dut_b (
    .clk_100hz(clk_100hz), .rst(rst_b), .text(b_text), .update_req(b_upd),
    .cursor_en(1'b0), .blink_en(1'b0), .cursor_addr(7'h00),
    .lcd_e(b_e), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_data(b_data), .busy(b_busy), .done(b_done)
  );

  always @(posedge clk_100hz) cycle <= cycle + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_base(input int n, input int cols);
    case (n)
      0:       return 7'h00;
      1:       return 7'h40;
      2:       return 7'(cols);
      default: return 7'(64 + cols);
    endcase
  endfunction

  task automatic push_wr(input int id, input logic start, input logic rs, input logic [7:0] data);
    wr_t w;
    w.start = start;
    w.rs    = rs;
    w.data  = data;
    if (id == 0) qa.push_back(w);
    else qb.push_back(w);
  endtask

  task automatic push_init(input int id, input int lines);
    push_wr(id, 1'b0, 1'b0, (lines > 1) ? 8'h38 : 8'h30);
    push_wr(id, 1'b0, 1'b0, 8'h0C);
    push_wr(id, 1'b0, 1'b0, 8'h06);
    push_wr(id, 1'b0, 1'b0, 8'h01);
  endtask

  task automatic push_refresh(input int id, input int lines, input int cols,
                              input logic [639:0] t, input logic [6:0] caddr);
    for (int n = 0; n < lines; n++) begin
      push_wr(id, n == 0, 1'b0, {1'b1, exp_base(n, cols)});
      for (int c = 0; c < cols; c++)
        push_wr(id, 1'b0, 1'b1, t[(lines * cols - 1 - (n * cols + c)) * 8 +: 8]);
    end
    push_wr(id, 1'b0, 1'b0, {1'b1, caddr});
  endtask

  task automatic mon_write(input int id, input logic rs, input logic rw, input logic [7:0] data);
    wr_t   w;
    string p;
    int    qs;
    p  = (id == 0) ? "a" : "b";
    qs = (id == 0) ? qa.size() : qb.size();
    check_value({p, "_rw"}, 32'(rw), 32'd0);
    if (qs == 0) begin
      check_value($sformatf("%s_unexpected_write_%0h", p, {rs, data}), 32'(qs), 32'd1);
      return;
    end
    if (id == 0) w = qa.pop_front();
    else w = qb.pop_front();
    check_value($sformatf("%s_write%0d", p, nwr[id]), 32'({rs, data}), 32'({w.rs, w.data}));
    nwr[id]++;
    if (w.start) start_cyc[id] = cycle;
  endtask

  task automatic mon_done(input int id);
    dones[id]++;
    check_value((id == 0) ? "a_latency" : "b_latency", 32'(cycle - start_cyc[id]),
                32'((id == 0) ? A_LAT : B_LAT));
  endtask

  always @(negedge clk_100hz) begin
    if (a_e) begin
      if (first_write_a < 0) first_write_a = cycle;
      mon_write(0, a_rs, a_rw, a_data);
    end
    if (a_done) mon_done(0);
    if (b_e) mon_write(1, b_rs, b_rw, b_data);
    if (b_done) mon_done(1);
  end

  task automatic wait_done(input int id, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100hz);
      if ((id == 0) ? a_done : b_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_value((id == 0) ? "a_done_seen" : "b_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle_a(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100hz);
      if (qa.size() == 0 && !a_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_value("a_drained", 32'(ok), 32'd1);
  endtask

  task automatic pulse_update_a();
    @(negedge clk_100hz);
    a_upd = 1'b1;
    @(negedge clk_100hz);
    a_upd = 1'b0;
  endtask

  task automatic random_text_a();
    for (int k = 0; k < A_LINES * A_COLS; k++) a_text[k*8 +: 8] = 8'($urandom_range(32, 126));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    int d0;
    rst_a   = 1'b0;
    rst_b   = 1'b0;
    a_upd   = 1'b0;
    b_upd   = 1'b0;
    a_cen   = 1'b0;
    a_ben   = 1'b0;
    a_caddr = 7'h00;
    a_text  = {"INITIAL TEXT 000", "SECOND LINE  001"};
    for (int k = 0; k < B_LINES * B_COLS; k++) b_text[k*8 +: 8] = 8'($urandom_range(32, 126));
    repeat (3) @(negedge clk_100hz);

    check_value("rst_lcd_e", 32'(a_e), 32'd0);
    check_value("rst_lcd_rs", 32'(a_rs), 32'd0);
    check_value("rst_lcd_rw", 32'(a_rw), 32'd0);
    check_value("rst_lcd_data", 32'(a_data), 32'd0);
    check_value("rst_busy", 32'(a_busy), 32'd1);
    check_value("rst_done", 32'(a_done), 32'd0);

    // 4x20 instance: init plus automatic refresh with its line addresses
    push_init(1, B_LINES);
    push_refresh(1, B_LINES, B_COLS, 640'(b_text), 7'h00);
    rst_b = 1'b1;
    wait_done(1, 800);
    check_value("b_queue_empty", 32'(qb.size()), 32'd0);

    // 2x16: power-on wait, init commands and automatic refresh
    push_init(0, A_LINES);
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), 7'h00);
    rel_cyc = cycle;
    rst_a = 1'b1;
    wait_done(0, 600);
    check_value("a_busy_at_done", 32'(a_busy), 32'd0);
    check_value("a_pwr_gap_ok", 32'((first_write_a - rel_cyc) >= PWR && (first_write_a - rel_cyc) <= PWR + 3), 32'd1);
    check_value("a_init_queue_empty", 32'(qa.size()), 32'd0);

    // Explicit refresh of a known string
    a_text = {"HELLO, WORLD 123", "LCD ENGINE TEST!"};
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), a_caddr);
    pulse_update_a();
    wait_done(0, 200);
    check_value("a_hello_busy", 32'(a_busy), 32'd0);
    check_value("a_hello_queue_empty", 32'(qa.size()), 32'd0);

    // Request mid-refresh: first refresh unchanged, exactly one more follows
    random_text_a();
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), a_caddr);
    pulse_update_a();
    repeat (12) @(negedge clk_100hz);
    random_text_a();
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), a_caddr);
    pulse_update_a();
    wait_done(0, 200);
    wait_done(0, 200);
    repeat (20) @(negedge clk_100hz);
    check_value("a_one_extra_busy", 32'(a_busy), 32'd0);
    check_value("a_one_extra_queue", 32'(qa.size()), 32'd0);

    // Mode and cursor change in the same idle cycle: mode first
    d0 = dones[0];
    @(negedge clk_100hz);
    a_cen   = 1'b1;
    a_caddr = 7'h45;
    push_wr(0, 1'b0, 1'b0, 8'h0E);
    push_wr(0, 1'b0, 1'b0, 8'hC5);
    wait_idle_a(60);
    check_value("a_no_done_on_rewrite", 32'(dones[0] - d0), 32'd0);

    // Changes during a refresh are served after done
    random_text_a();
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), 7'h10);
    pulse_update_a();
    repeat (20) @(negedge clk_100hz);
    a_ben   = 1'b1;
    a_caddr = 7'h10;
    push_wr(0, 1'b0, 1'b0, 8'h0F);
    push_wr(0, 1'b0, 1'b0, 8'h90);
    wait_done(0, 200);
    wait_idle_a(60);

    @(negedge clk_100hz);
    a_cen   = 1'b0;
    a_ben   = 1'b0;
    a_caddr = 7'h00;
    push_wr(0, 1'b0, 1'b0, 8'h0C);
    push_wr(0, 1'b0, 1'b0, 8'h80);
    wait_idle_a(60);

    // Reset in LINE_DATA aborts at once, then full re-initialisation
    random_text_a();
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), 7'h00);
    pulse_update_a();
    repeat (15) @(negedge clk_100hz);
    rst_a = 1'b0;
    #1;
    check_value("midrst_lcd_e", 32'(a_e), 32'd0);
    check_value("midrst_lcd_rs", 32'(a_rs), 32'd0);
    check_value("midrst_lcd_data", 32'(a_data), 32'd0);
    check_value("midrst_busy", 32'(a_busy), 32'd1);
    check_value("midrst_done", 32'(a_done), 32'd0);
    qa.delete();
    push_init(0, A_LINES);
    push_refresh(0, A_LINES, A_COLS, 640'(a_text), 7'h00);
    repeat (3) @(negedge clk_100hz);
    first_write_a = -1;
    rel_cyc = cycle;
    rst_a = 1'b1;
    wait_done(0, 600);
    check_value("a_reinit_pwr_gap_ok", 32'((first_write_a - rel_cyc) >= PWR && (first_write_a - rel_cyc) <= PWR + 3), 32'd1);
    repeat (10) @(negedge clk_100hz);
    check_value("a_final_queue_empty", 32'(qa.size()), 32'd0);
    check_value("b_final_queue_empty", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
